dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 31 +++
 rtl/dmem_responder_array.sv | 25 ++
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the single-outstanding data-memory responder.
package dmem_responder_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int MAX_LATENCY = 15;

  // Byte-offset bits inside a word and width of the latency counter.
  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int CNT_W = $clog2(MAX_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request as captured on the accepting edge.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } req_t;

  // Misaligned, or word index beyond the populated storage.
  function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = addr >> OFF_W;
    return (addr[OFF_W-1:0] != '0) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// DEPTH x 32 word RAM: synchronous write, asynchronous read.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // NOTE: storage has no reset; 2-state 'bit' elements start at zero, and reset must never wipe contents.
  bit [31:0] mem [DEPTH];

  // Word write on the execute edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed LATENCY (1..15) from
// acceptance to response, misaligned/out-of-range accesses flagged as errors.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;

  logic             exec_err;
  logic             mem_we;
  logic [31:0]      mem_rdata;

  // Error status of the latched request, evaluated on the execute edge.
  assign exec_err = addr_error(req_q.addr, 32'(DEPTH));

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (req_q.addr[AW+OFF_W-1:OFF_W]),
    .wdata (req_q.wdata),
    .rdata (mem_rdata)
  );

  // Next-state, counter, request latch and response capture.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = '{addr: req_addr, write: req_write, wdata: req_wdata};
          cnt_d   = LAT_INIT;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          // Execute: errored stores leave storage alone, loads of bad addresses read as zero.
          mem_we       = req_q.write && !exec_err;
          resp_rdata_d = (req_q.write || exec_err) ? 32'h0 : mem_rdata;
          resp_err_d   = exec_err;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any pending access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: transaction-level model checked every cycle on the
// LATENCY=4 instance, plus a LATENCY=1 instance for back-to-back timing.
module tb_dmem_responder;

  localparam int LAT = 4;
  localparam int DEP = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_resp_rdata;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEP), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .req_write(b_req_write), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of the LATENCY=4 instance ----------
  // A request is outstanding from its accepting edge; the response becomes
  // visible LAT edges later and stays until it is consumed.
  function automatic bit model_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEP);
  endfunction

  bit [31:0]   m_mem [DEP];
  logic        m_pend = 1'b0;
  int          m_age = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic        m_write = 1'b0, m_err = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend <= 1'b0;
      m_age  <= 0;
    end else if (!m_pend) begin
      if (req_valid) begin
        m_pend  <= 1'b1;
        m_age   <= 0;
        m_addr  <= req_addr;
        m_write <= req_write;
        m_wdata <= req_wdata;
      end
    end else if (m_age < LAT) begin
      m_age <= m_age + 1;
      if (m_age == LAT - 1) begin
        m_err   <= model_bad(m_addr);
        m_rdata <= (m_write || model_bad(m_addr)) ? 32'h0 : m_mem[(m_addr / 4) % DEP];
        if (m_write && !model_bad(m_addr)) m_mem[m_addr / 4] <= m_wdata;
      end
    end else if (resp_ready) begin
      m_pend <= 1'b0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (reset === 1'b1 && cmp_en) begin
      check("req_ready", 32'(req_ready), 32'(!m_pend));
      check("busy", 32'(busy), 32'(m_pend));
      check("resp_valid", 32'(resp_valid), 32'(m_pend && m_age == LAT));
      if (m_pend && m_age == LAT) begin
        check("resp_rdata", resp_rdata, m_rdata);
        check("resp_err", 32'(resp_err), 32'(m_err));
      end
    end
  end

  // One request on the LATENCY=4 instance. With scramble set, req_valid stays
  // high and addr/wdata/write are inverted after acceptance.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int stall, input bit scramble,
                        output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (scramble) begin
      req_addr = ~a; req_wdata = ~d; req_write = ~w;
    end else begin
      req_valid = 1'b0;
    end
    lat = 0; n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      lat++; n++;
    end
    if (resp_valid !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout: no resp_valid within 40 cycles for addr %h", a);
    end
    rd = resp_rdata;
    e  = resp_err;
    repeat (stall) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          acc_edge, n_acc, n_rsp;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst1_req_ready", 32'(b_req_ready), 32'd1);
    check("rst1_resp_valid", 32'(b_resp_valid), 32'd0);
    reset = 1'b1;
    cmp_en = 1'b1;

    // Store then load at 0x10.
    do_req(32'h10, 1'b1, 32'hDEADBEEF, 0, 1'b0, rd, e, lat);
    check("st10_err", 32'(e), 32'd0);
    check("st10_rdata", rd, 32'h0);
    check("st10_latency", 32'(lat), 32'd4);
    do_req(32'h10, 1'b0, 32'h0, 0, 1'b0, rd, e, lat);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err", 32'(e), 32'd0);
    check("ld10_latency", 32'(lat), 32'd4);

    // Misaligned load and out-of-range store.
    do_req(32'h13, 1'b0, 32'h0, 0, 1'b0, rd, e, lat);
    check("ld13_err", 32'(e), 32'd1);
    check("ld13_rdata", rd, 32'h0);
    do_req(32'h0, 1'b1, 32'h11111111, 0, 1'b0, rd, e, lat);
    do_req(32'h1000, 1'b1, 32'hCAFEF00D, 0, 1'b0, rd, e, lat);
    check("st1000_err", 32'(e), 32'd1);
    check("st1000_rdata", rd, 32'h0);
    do_req(32'h0, 1'b0, 32'h0, 0, 1'b0, rd, e, lat);
    check("ld0_unchanged", rd, 32'h11111111);
    do_req(32'hFFC, 1'b0, 32'h0, 0, 1'b0, rd, e, lat);
    check("ldFFC_rdata", rd, 32'h0);
    check("ldFFC_err", 32'(e), 32'd0);

    // Stalled response with req_valid held high and inputs changing.
    do_req(32'h10, 1'b0, 32'h0, 10, 1'b1, rd, e, lat);
    check("stall_rdata", rd, 32'hDEADBEEF);
    check("stall_after_idle", 32'(req_ready), 32'd1);

    // Inputs changed during WAIT do not leak into the access.
    do_req(32'h40, 1'b1, 32'h55AA55AA, 0, 1'b1, rd, e, lat);
    check("scr_st_err", 32'(e), 32'd0);
    do_req(32'h40, 1'b0, 32'h0, 0, 1'b1, rd, e, lat);
    check("scr_ld_rdata", rd, 32'h55AA55AA);
    check("scr_ld_err", 32'(e), 32'd0);

    // Reset two cycles into a store: the store must never land.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h20; req_write = 1'b1; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("postrst_req_ready", 32'(req_ready), 32'd1);
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_resp_valid", 32'(resp_valid), 32'd0);
    do_req(32'h20, 1'b0, 32'h0, 0, 1'b0, rd, e, lat);
    check("ld20_prior", rd, 32'h0);
    check("ld20_err", 32'(e), 32'd0);

    // LATENCY=1 instance: back-to-back requests with resp_ready high. Each
    // response is visible one edge after acceptance; handshake takes the next
    // edge, so acceptances are LATENCY+2 = 3 edges apart.
    cmp_en = 1'b0;
    @(negedge clk);
    b_resp_ready = 1'b1; b_req_valid = 1'b1;
    b_req_addr = 32'h8; b_req_write = 1'b1; b_req_wdata = 32'h0BADF00D;
    acc_edge = -10; n_acc = 0; n_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      if (b_resp_valid === 1'b1) begin
        check("b2b_latency", 32'(c - acc_edge), 32'd1);
        check("b2b_rdata", b_resp_rdata, (n_rsp == 0) ? 32'h0 : 32'h0BADF00D);
        check("b2b_err", 32'(b_resp_err), 32'd0);
        n_rsp++;
        b_req_write = 1'b0;
      end
      if (b_req_ready === 1'b1) begin
        if (n_acc > 0) check("b2b_gap", 32'((c + 1) - acc_edge), 32'd3);
        acc_edge = c + 1;
        n_acc++;
      end
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd4);
    check("b2b_responses", 32'(n_rsp), 32'd4);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
